// File: rtl/wb_mem_arbiter.sv
// Two-master (fetch i*, load/store d*) to one-slave Wishbone arbiter; grant is held per bus cycle.
// Optional stall watchdog enabled by defining WB_TIMEOUT_EN.
module wb_mem_arbiter #(
   parameter int DATA_PRIORITY  = 1,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] iaddr_i,
   input  logic [31:0] idat_i,
   input  logic [3:0]  isel_i,
   input  logic        icyc_i,
   input  logic        istb_i,
   input  logic        iwe_i,
   output logic [31:0] idat_o,
   output logic        iack_o,
   output logic        ierr_o,
   input  logic [31:0] daddr_i,
   input  logic [31:0] ddat_i,
   input  logic [3:0]  dsel_i,
   input  logic        dcyc_i,
   input  logic        dstb_i,
   input  logic        dwe_i,
   output logic [31:0] ddat_o,
   output logic        dack_o,
   output logic        derr_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_dat_o,
   output logic [3:0]  mem_sel_o,
   output logic        mem_cyc_o,
   output logic        mem_stb_o,
   output logic        mem_we_o,
   input  logic [31:0] mem_dat_i,
   input  logic        mem_ack_i,
   input  logic        mem_err_i,
   output logic [1:0]  grant_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GNT_I = 2'b01,
      GNT_D = 2'b10
   } state_t;

   state_t     state;
   state_t     state_next;
   state_t     pick;
   logic       last_d;
   logic [1:0] grant_q;
   logic       own_i;
   logic       own_d;
   logic       own_stb;
   logic       timeout;

   // Winner if the bus were free this cycle; on a tie round-robin gives it to the master not served last.
   always_comb begin
      pick = IDLE;
      if (icyc_i && dcyc_i)
         pick = (DATA_PRIORITY != 0 || !last_d) ? GNT_D : GNT_I;
      else if (icyc_i)
         pick = GNT_I;
      else if (dcyc_i)
         pick = GNT_D;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = pick;
         GNT_I:   if (!icyc_i) state_next = pick;
         GNT_D:   if (!dcyc_i) state_next = pick;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         last_d  <= 1'b0;
         grant_q <= 2'b00;
      end else begin
         state   <= state_next;
         grant_q <= state_next;
         if (state_next == GNT_I) last_d <= 1'b0;
         else if (state_next == GNT_D) last_d <= 1'b1;
      end
   end

   assign grant_o = grant_q;
   assign own_i   = (state == GNT_I);
   assign own_d   = (state == GNT_D);
   assign own_stb = (own_i & istb_i) | (own_d & dstb_i);

`ifdef WB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CW-1:0] stall_cnt;

   assign timeout = own_stb && (stall_cnt == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stall_cnt <= '0;
      else if ((state_next != state) || timeout || mem_ack_i || mem_err_i)
         stall_cnt <= '0;
      else if (mem_stb_o)
         stall_cnt <= stall_cnt + 1'b1;
   end
`else
   assign timeout = 1'b0;
`endif

   // Slave side follows the owner combinationally and is all-zero with no owner.
   assign mem_addr_o = own_i ? iaddr_i : (own_d ? daddr_i : 32'h0);
   assign mem_dat_o  = own_i ? idat_i  : (own_d ? ddat_i  : 32'h0);
   assign mem_sel_o  = own_i ? isel_i  : (own_d ? dsel_i  : 4'h0);
   assign mem_cyc_o  = (own_i & icyc_i) | (own_d & dcyc_i);
   assign mem_we_o   = (own_i & iwe_i)  | (own_d & dwe_i);
   assign mem_stb_o  = own_stb & ~timeout;

   assign iack_o = own_i & istb_i & mem_ack_i;
   assign dack_o = own_d & dstb_i & mem_ack_i;
   assign ierr_o = own_i & ((istb_i & mem_err_i) | timeout);
   assign derr_o = own_d & ((dstb_i & mem_err_i) | timeout);
   assign idat_o = own_i ? mem_dat_i : 32'h0;
   assign ddat_o = own_d ? mem_dat_i : 32'h0;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Bench for wb_mem_arbiter: instance 0 round-robin, instance 1 data priority, both on shared stimulus.
module tb_wb_mem_arbiter;

   localparam int T = 16;
`ifdef WB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [31:0] iaddr_i, idat_i, daddr_i, ddat_i, mem_dat_i;
   logic [3:0]  isel_i, dsel_i;
   logic        icyc_i, istb_i, iwe_i, dcyc_i, dstb_i, dwe_i, mem_ack_i, mem_err_i;

   logic [31:0] idat_w [2];
   logic [31:0] ddat_w [2];
   logic [31:0] maddr_w [2];
   logic [31:0] mdat_w [2];
   logic [3:0]  msel_w [2];
   logic [1:0]  grant_w [2];
   logic        iack_w [2];
   logic        ierr_w [2];
   logic        dack_w [2];
   logic        derr_w [2];
   logic        mcyc_w [2];
   logic        mstb_w [2];
   logic        mwe_w [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      wb_mem_arbiter #(.DATA_PRIORITY(g), .TIMEOUT_CYCLES(T)) u_dut (
         .clk(clk), .rst(rst),
         .iaddr_i(iaddr_i), .idat_i(idat_i), .isel_i(isel_i),
         .icyc_i(icyc_i), .istb_i(istb_i), .iwe_i(iwe_i),
         .idat_o(idat_w[g]), .iack_o(iack_w[g]), .ierr_o(ierr_w[g]),
         .daddr_i(daddr_i), .ddat_i(ddat_i), .dsel_i(dsel_i),
         .dcyc_i(dcyc_i), .dstb_i(dstb_i), .dwe_i(dwe_i),
         .ddat_o(ddat_w[g]), .dack_o(dack_w[g]), .derr_o(derr_w[g]),
         .mem_addr_o(maddr_w[g]), .mem_dat_o(mdat_w[g]), .mem_sel_o(msel_w[g]),
         .mem_cyc_o(mcyc_w[g]), .mem_stb_o(mstb_w[g]), .mem_we_o(mwe_w[g]),
         .mem_dat_i(mem_dat_i), .mem_ack_i(mem_ack_i), .mem_err_i(mem_err_i),
         .grant_o(grant_w[g])
      );
   end

   int checks = 0;
   int errors = 0;

   // Reference model: current owner (0 none, 1 fetch, 2 data), last served master, stalled cycles.
   int owner [2];
   int last  [2];
   int stall [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #2;
   endtask

   function automatic bit own_stb(int k);
      return (owner[k] == 1) ? istb_i : (owner[k] == 2) ? dstb_i : 1'b0;
   endfunction

   function automatic bit model_to(int k);
      return TO_EN && own_stb(k) && (stall[k] == T - 1);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         owner[k] = 0;
         last[k]  = 1;
         stall[k] = 0;
      end
   endtask

   task automatic check_model(int k);
      int  o;
      bit  to;
      o  = owner[k];
      to = model_to(k);
      chk($sformatf("u%0d.grant", k), 32'(grant_w[k]), (o == 1) ? 32'd1 : (o == 2) ? 32'd2 : 32'd0);
      chk($sformatf("u%0d.addr", k), maddr_w[k], (o == 1) ? iaddr_i : (o == 2) ? daddr_i : 32'h0);
      chk($sformatf("u%0d.wdat", k), mdat_w[k], (o == 1) ? idat_i : (o == 2) ? ddat_i : 32'h0);
      chk($sformatf("u%0d.sel", k), 32'(msel_w[k]), (o == 1) ? 32'(isel_i) : (o == 2) ? 32'(dsel_i) : 32'h0);
      chk($sformatf("u%0d.cyc", k), 32'(mcyc_w[k]), (o == 1) ? 32'(icyc_i) : (o == 2) ? 32'(dcyc_i) : 32'h0);
      chk($sformatf("u%0d.we", k), 32'(mwe_w[k]), (o == 1) ? 32'(iwe_i) : (o == 2) ? 32'(dwe_i) : 32'h0);
      chk($sformatf("u%0d.stb", k), 32'(mstb_w[k]), 32'(own_stb(k) && !to));
      chk($sformatf("u%0d.iack", k), 32'(iack_w[k]), 32'(o == 1 && istb_i && mem_ack_i));
      chk($sformatf("u%0d.dack", k), 32'(dack_w[k]), 32'(o == 2 && dstb_i && mem_ack_i));
      chk($sformatf("u%0d.ierr", k), 32'(ierr_w[k]), 32'(o == 1 && ((istb_i && mem_err_i) || to)));
      chk($sformatf("u%0d.derr", k), 32'(derr_w[k]), 32'(o == 2 && ((dstb_i && mem_err_i) || to)));
      chk($sformatf("u%0d.idat", k), idat_w[k], (o == 1) ? mem_dat_i : 32'h0);
      chk($sformatf("u%0d.ddat", k), ddat_w[k], (o == 2) ? mem_dat_i : 32'h0);
   endtask

   // Clock-edge update from the inputs present just before the edge.
   task automatic update_model(int k);
      int  o, n;
      bit  own_cyc, to, stb;
      o       = owner[k];
      own_cyc = (o == 1) ? icyc_i : (o == 2) ? dcyc_i : 1'b0;
      to      = model_to(k);
      stb     = own_stb(k) && !to;
      n       = o;
      if (o == 0 || !own_cyc) begin
         if (icyc_i && dcyc_i) n = (k == 1 || last[k] == 1) ? 2 : 1;
         else if (icyc_i)      n = 1;
         else if (dcyc_i)      n = 2;
         else                  n = 0;
      end
      if (n != o || to || mem_ack_i || mem_err_i) stall[k] = 0;
      else if (stb) stall[k] = stall[k] + 1;
      if (n != 0) last[k] = n;
      owner[k] = n;
   endtask

   task automatic clear_inputs();
      {iaddr_i, idat_i, daddr_i, ddat_i, mem_dat_i} = '0;
      {isel_i, dsel_i} = '0;
      {icyc_i, istb_i, iwe_i, dcyc_i, dstb_i, dwe_i, mem_ack_i, mem_err_i} = '0;
   endtask

   initial begin
      logic [1:0] exp_g;
      bit         exp_e;

      // Reset held with a fetch request pending and a stray slave ack.
      clear_inputs();
      rst = 1'b0;
      icyc_i = 1'b1; istb_i = 1'b1; iaddr_i = 32'h0000_0004; mem_ack_i = 1'b1;
      #12;
      chk("rst.grant1", 32'(grant_w[1]), 32'd0);
      chk("rst.grant0", 32'(grant_w[0]), 32'd0);
      chk("rst.cyc", 32'(mcyc_w[1]), 32'd0);
      chk("rst.iack", 32'(iack_w[1]), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      adv();
      chk("rel.grant", 32'(grant_w[1]), 32'd1);
      chk("rel.addr", maddr_w[1], 32'h0000_0004);

      // Fetch read with slave ack.
      mem_dat_i = 32'h2364_7862;
      #1;
      chk("rd.idat", idat_w[1], 32'h2364_7862);
      chk("rd.iack", 32'(iack_w[1]), 32'd1);
      chk("rd.dack", 32'(dack_w[1]), 32'd0);
      chk("rd.ddat", ddat_w[1], 32'h0);
      mem_ack_i = 1'b0; icyc_i = 1'b0; istb_i = 1'b0;
      adv();
      chk("rd.release", 32'(grant_w[1]), 32'd0);

      // Simultaneous requests, then handover with no idle gap.
      icyc_i = 1'b1; istb_i = 1'b1; dcyc_i = 1'b1; dstb_i = 1'b1;
      adv();
      chk("cont.prio", 32'(grant_w[1]), 32'd2);
      chk("cont.rr", 32'(grant_w[0]), 32'd2);
      dcyc_i = 1'b0; dstb_i = 1'b0;
      adv();
      chk("cont.hand1", 32'(grant_w[1]), 32'd1);
      chk("cont.hand0", 32'(grant_w[0]), 32'd1);
      icyc_i = 1'b0; istb_i = 1'b0;
      adv();
      chk("cont.idle", 32'(grant_w[0]), 32'd0);

      // Round-robin: fetch was served last, so data wins the tie, then owners alternate.
      icyc_i = 1'b1; istb_i = 1'b1; dcyc_i = 1'b1; dstb_i = 1'b1;
      adv();
      exp_g = 2'b10;
      chk("rr.first", 32'(grant_w[0]), 32'(exp_g));
      for (int n = 0; n < 4; n++) begin
         icyc_i = (exp_g == 2'b01) ? 1'b0 : 1'b1;
         dcyc_i = (exp_g == 2'b10) ? 1'b0 : 1'b1;
         mem_ack_i = 1'b1;
         adv();
         exp_g = (exp_g == 2'b10) ? 2'b01 : 2'b10;
         chk("rr.alt", 32'(grant_w[0]), 32'(exp_g));
      end
      clear_inputs();
      adv();
      chk("rr.idle", 32'(grant_w[0]), 32'd0);

      // Slave error on a data access; grant kept until dcyc falls.
      daddr_i = 32'h0000_0002; dcyc_i = 1'b1; dstb_i = 1'b1;
      adv();
      chk("err.grant", 32'(grant_w[1]), 32'd2);
      chk("err.addr", maddr_w[1], 32'h0000_0002);
      mem_err_i = 1'b1;
      #1;
      chk("err.derr", 32'(derr_w[1]), 32'd1);
      chk("err.ierr", 32'(ierr_w[1]), 32'd0);
      adv();
      chk("err.hold", 32'(grant_w[1]), 32'd2);
      mem_err_i = 1'b0; dcyc_i = 1'b0; dstb_i = 1'b0;
      adv();
      chk("err.rel", 32'(grant_w[1]), 32'd0);

      // Slave never answers a fetch strobe.
      icyc_i = 1'b1; istb_i = 1'b1; iaddr_i = 32'h0000_0040;
      adv();
      chk("to.grant", 32'(grant_w[1]), 32'd1);
      for (int n = 0; n < 18; n++) begin
         exp_e = TO_EN && (n == T - 1);
         chk("to.ierr", 32'(ierr_w[1]), 32'(exp_e));
         chk("to.stb", 32'(mstb_w[1]), 32'(!exp_e));
         adv();
      end

      // Asynchronous reset in the middle of a granted cycle.
      mem_dat_i = 32'hdead_beef;
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      chk("arst.grant", 32'(grant_w[1]), 32'd0);
      chk("arst.cyc", 32'(mcyc_w[1]), 32'd0);
      chk("arst.stb", 32'(mstb_w[1]), 32'd0);
      chk("arst.idat", idat_w[1], 32'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;

      // Randomized traffic against the model; the middle stretch has a slow slave.
      for (int n = 0; n < 2000; n++) begin
         @(posedge clk);
         update_model(0);
         update_model(1);
         #1;
         if ($urandom_range(0, 3) == 0) icyc_i = ~icyc_i;
         if ($urandom_range(0, 3) == 0) dcyc_i = ~dcyc_i;
         istb_i    = ($urandom_range(0, 9) < 8);
         dstb_i    = ($urandom_range(0, 9) < 8);
         iwe_i     = $urandom_range(0, 1);
         dwe_i     = $urandom_range(0, 1);
         isel_i    = 4'($urandom);
         dsel_i    = 4'($urandom);
         iaddr_i   = $urandom;
         daddr_i   = $urandom;
         idat_i    = $urandom;
         ddat_i    = $urandom;
         mem_dat_i = $urandom;
         if (n >= 800 && n < 1400) begin
            mem_ack_i = ($urandom_range(0, 99) < 3);
            mem_err_i = ($urandom_range(0, 99) < 1);
         end else begin
            mem_ack_i = ($urandom_range(0, 9) < 3);
            mem_err_i = ($urandom_range(0, 99) < 8);
         end
         #3;
         check_model(0);
         check_model(1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
